uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter; define UART_TX_PARITY_EN to enable the parity bit.
module uart_tx_buffered #(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16,
    parameter int CLOCK_CTR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic [1:0]                    parity_type,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx_serial
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [DATA_BITS-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [LVL_W-1:0]           count;
    logic [2:0]                 state;
    logic [CLOCK_CTR_WIDTH-1:0] clk_cnt;
    logic [IDX_W-1:0]           bit_idx;
    logic                       stop_idx;
    logic [DATA_BITS-1:0]       shreg;
    logic                       tx_q;
    logic                       push;
    logic                       pop;
    logic                       bit_end;
    logic                       stop_last;
    logic [DATA_BITS-1:0]       head;

    assign full      = (count == LVL_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign level     = count;
    assign busy      = (state != S_IDLE);
    assign tx_serial = tx_q;
    assign head      = mem[rd_ptr];

    // Writes are judged against the current full flag, so a pop in the same cycle cannot rescue them.
    assign push      = wr_en && !full;
    assign bit_end   = (clk_cnt == CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1));
    assign stop_last = bit_end && (stop_idx == 1'(STOP_BITS - 1));
    assign pop       = !empty && ((state == S_IDLE) || ((state == S_STOP) && stop_last));

`ifdef UART_TX_PARITY_EN
    logic par_en;
    logic par_bit;
    logic par_en_next;
    logic par_bit_next;

    assign par_en_next  = (parity_type == 2'd1) || (parity_type == 2'd2);
    assign par_bit_next = (^head) ^ (parity_type == 2'd1);
`else
    logic unused_parity;
    assign unused_parity = ^parity_type;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
`endif
        end else if (pop) begin
            // Loading a frame from IDLE or straight out of the last stop bit.
            state    <= S_START;
            clk_cnt  <= '0;
            shreg    <= head;
            tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en   <= par_en_next;
            par_bit  <= par_bit_next;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    tx_q    <= 1'b1;
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx_q    <= shreg[0];
                    end else begin
                        clk_cnt <= clk_cnt + CLOCK_CTR_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en) begin
                                state <= S_PARITY;
                                tx_q  <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                stop_idx <= 1'b0;
                                tx_q     <= 1'b1;
                            end
`else
                            state    <= S_STOP;
                            stop_idx <= 1'b0;
                            tx_q     <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLOCK_CTR_WIDTH'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt  <= '0;
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        tx_q     <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CLOCK_CTR_WIDTH'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (stop_last) begin
                        clk_cnt <= '0;
                        state   <= S_IDLE;
                        tx_q    <= 1'b1;
                    end else if (bit_end) begin
                        clk_cnt  <= '0;
                        stop_idx <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CLOCK_CTR_WIDTH'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    clk_cnt <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
